step_ctrl: RTL and testbench

//  Consumes the slow divided clock from the clock divider and turns it into a one-Clk-wide

---
 rtl/step_ctrl.sv | 141 ++++++++++++++
 tb/tb_step_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: turns the slow divided clock into a one-Clk-wide datapath enable (CpuEn)
// with run / single-step / halt control. Everything runs on the fast board Clk.
// Optional build macro STEP_CTRL_CYCLE_CNT_EN adds the CycleCnt output and its counter.
module step_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned DEB_W      = 20,
    parameter int unsigned CNT_W      = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic SlowClk,
    input  logic RunSw,
    input  logic StepBtn,
    input  logic HaltReq,
    output logic CpuEn,
    output logic Running
`ifdef STEP_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt
`endif
);

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP_ARM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_cpu_en_nxt;

    logic r_slow_s1, r_slow_s2, r_slow_prev;
    logic r_run_s1, r_run_s2;
    logic r_btn_s1, r_btn_s2, r_btn_deb, r_press;
    logic [DEB_W-1:0] r_deb_cnt;
    logic w_tick;

    // Synchronize SlowClk, RunSw and StepBtn into the Clk domain; keep last SlowClk level
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_prev <= 1'b0;
            r_run_s1    <= 1'b0;
            r_run_s2    <= 1'b0;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
        end else begin
            r_slow_s1   <= SlowClk;
            r_slow_s2   <= r_slow_s1;
            r_slow_prev <= r_slow_s2;
            r_run_s1    <= RunSw;
            r_run_s2    <= r_run_s1;
            r_btn_s1    <= StepBtn;
            r_btn_s2    <= r_btn_s1;
        end
    end

    // Only rising edges of the slow clock produce a tick
    assign w_tick = r_slow_s2 & ~r_slow_prev;

    // Debounce: count consecutive cycles the synced button disagrees with the debounced
    // level; any return to agreement restarts the count. Press pulses on an accepted 0->1.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_btn_deb <= 1'b0;
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_btn_s2 == r_btn_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_btn_deb <= r_btn_s2;
                r_deb_cnt <= '0;
                r_press   <= r_btn_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Next-state and enable decode; HaltReq overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_en_nxt = 1'b0;
        if (HaltReq) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (r_run_s2)     w_state_nxt = ST_RUN;
                    else if (r_press) w_state_nxt = ST_STEP_ARM;
                end
                ST_RUN: begin
                    if (!r_run_s2)    w_state_nxt = ST_HALT;
                    else if (w_tick)  w_cpu_en_nxt = 1'b1;
                end
                ST_STEP_ARM: begin
                    if (r_run_s2) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_tick) begin
                        w_cpu_en_nxt = 1'b1;
                        w_state_nxt  = ST_HALT;
                    end
                end
                default: w_state_nxt = ST_HALT;
            endcase
        end
    end

    // State register plus registered outputs; Running follows the next state
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_HALT;
            CpuEn   <= 1'b0;
            Running <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            CpuEn   <= w_cpu_en_nxt;
            Running <= (w_state_nxt == ST_RUN);
        end
    end

`ifdef STEP_CTRL_CYCLE_CNT_EN
    // Count issued enables; wraps naturally at 2^CNT_W
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            CycleCnt <= '0;
        end else if (w_cpu_en_nxt) begin
            CycleCnt <= CycleCnt + CNT_W'(1);
        end
    end
`else
    // No counter in this build; CNT_W is kept so parameter overrides stay valid
    if (CNT_W == 0) begin : g_no_cycle_cnt
    end
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: table of control scenarios, each ending in one SlowClk period,
// plus hand-written reset and counter sequences. Expected CpuEn cycles go in a queue.
module tb_step_ctrl;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic SlowClk = 1'b0;
    logic RunSw = 1'b0;
    logic StepBtn = 1'b0;
    logic HaltReq = 1'b0;
    logic CpuEn;
    logic Running;
`ifdef STEP_CTRL_CYCLE_CNT_EN
    logic [3:0] CycleCnt;
    logic [3:0] exp_cnt = 4'd0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sb[$];

    step_ctrl #(
        .DEB_CYCLES(4),
        .DEB_W(20),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .SlowClk(SlowClk),
        .RunSw(RunSw),
        .StepBtn(StepBtn),
        .HaltReq(HaltReq),
        .CpuEn(CpuEn),
        .Running(Running)
`ifdef STEP_CTRL_CYCLE_CNT_EN
        ,
        .CycleCnt(CycleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse monitor: every CpuEn sample must match the head of the expected queue
    always @(negedge Clk) begin
        if (Rst) begin
`ifdef STEP_CTRL_CYCLE_CNT_EN
            exp_cnt = 4'd0;
`endif
        end else if (CpuEn) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", cyc, -1);
            end else begin
                check("pulse_cycle", cyc, sb.pop_front());
            end
`ifdef STEP_CTRL_CYCLE_CNT_EN
            exp_cnt = exp_cnt + 4'd1;
            check("cycle_cnt", int'(CycleCnt), int'(exp_cnt));
`endif
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // One 20-Clk SlowClk period; optional HaltReq on the cycle the tick is consumed
    task automatic slow_period(input bit exp_pulse, input bit halt);
        tick_n(1);
        SlowClk = 1'b1;
        if (exp_pulse) sb.push_back(cyc + 3);
        tick_n(2);
        HaltReq = halt;
        tick_n(1);
        HaltReq = 1'b0;
        if (halt) begin
            check("halt_running", int'(Running), 0);
            tick_n(1);
            check("resume_running", int'(Running), 1);
            tick_n(6);
        end else begin
            tick_n(7);
        end
        SlowClk = 1'b0;
        tick_n(9);
    endtask

    task automatic btn_hold(input int n);
        StepBtn = 1'b1;
        tick_n(n);
        StepBtn = 1'b0;
        tick_n(10);
    endtask

    typedef struct {
        bit run_sw;
        int press;      // 0 none, 1 clean, 2 bouncy, 3 two presses
        bit halt;
        bit exp_pulse;
        bit exp_run;
    } vec_t;

    vec_t vt[17];

    initial begin
        vt[0]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 2, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 3, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 0, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
        vt[14] = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1, 1'b0, 1'b1, 1'b1};
        vt[16] = '{1'b0, 0, 1'b0, 1'b0, 1'b0};

        // Reset state
        tick_n(2);
        check("rst_cpuen", int'(CpuEn), 0);
        check("rst_running", int'(Running), 0);
`ifdef STEP_CTRL_CYCLE_CNT_EN
        check("rst_cyclecnt", int'(CycleCnt), 0);
`endif
        Rst = 1'b0;
        RunSw = 1'b1;
        tick_n(4);
        check("run_entry", int'(Running), 1);

        // Reset in the middle of an enable pulse
        SlowClk = 1'b1;
        tick_n(3);
        check("pulse_before_rst", int'(CpuEn), 1);
        #1 Rst = 1'b1;
        #1;
        check("midrst_cpuen", int'(CpuEn), 0);
        check("midrst_running", int'(Running), 0);
        tick_n(2);
        Rst = 1'b0;
        tick_n(6);
        check("run_after_rst", int'(Running), 1);
        SlowClk = 1'b0;
        tick_n(10);

        // Scenario table
        for (int i = 0; i < 17; i++) begin
            case (vt[i].press)
                1: btn_hold(10);
                2: begin
                    StepBtn = 1'b1;
                    tick_n(2);
                    StepBtn = 1'b0;
                    tick_n(2);
                    btn_hold(10);
                end
                3: begin
                    btn_hold(10);
                    btn_hold(10);
                end
                default: ;
            endcase
            RunSw = vt[i].run_sw;
            tick_n(4);
            slow_period(vt[i].exp_pulse, vt[i].halt);
            check($sformatf("row%0d_running", i), int'(Running), int'(vt[i].exp_run));
            check($sformatf("row%0d_pending", i), sb.size(), 0);
        end

        // Long free run; with the counter enabled this wraps a 4-bit CycleCnt
        RunSw = 1'b1;
        tick_n(4);
        for (int k = 0; k < 17; k++) slow_period(1'b1, 1'b0);
        check("long_run_running", int'(Running), 1);
        check("long_run_pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
